fp_alu_sched: RTL and testbench

//  Shares one double-precision FP add/sub ALU (combinational; ctrl 00=add, 01=sub, others -> 0) between two requesters.
//  2-way round-robin arbiter, LAT-stage result pipe and one response port with valid/ready backpressure.

---
 rtl/fp_alu_pkg.sv | 23 ++
 rtl/fp_alu_sched_if.sv | 46 ++++
 rtl/fp_alu_rr_arb.sv | 35 +++
 rtl/fp_alu_sched.sv | 153 +++++++++++++++
 tb/tb_fp_alu_sched.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_alu_pkg.sv
// fp_alu_pkg
//   Shared definitions for the FP ALU scheduler: floating-point word width
//   derivation, ALU op encodings and the widths of the per-stage record
//   fields (op, source) carried through the result pipe.
package fp_alu_pkg;

   localparam int OP_W  = 2;   // op field width (ALU ctrl)
   localparam int SRC_W = 1;   // originating requester index

   localparam logic [OP_W-1:0] FP_OP_ADD = 2'b00;
   localparam logic [OP_W-1:0] FP_OP_SUB = 2'b01;

   // sign + exponent + fraction
   function automatic int fp_width(input int frac_w, input int exp_w);
      return frac_w + exp_w + 1;
   endfunction

   // Anything other than add/sub is reported back as an error with zero data.
   function automatic logic op_illegal(input logic [OP_W-1:0] op);
      return !((op == FP_OP_ADD) || (op == FP_OP_SUB));
   endfunction

endpackage

// File: rtl/fp_alu_sched_if.sv
// fp_alu_sched_if
//   Request/response bundle of the FP ALU scheduler.
//   req0_* / req1_* : two requesters (valid/ready, operands a/b, op, tag)
//   rsp_*           : single response port (valid/ready, src, tag, data, err)
//   master : requester/consumer side    slave : scheduler side
interface fp_alu_sched_if #(
   parameter int FP_W  = 64,
   parameter int TAG_W = 4
);
   logic             req0_valid_i;
   logic             req0_ready_o;
   logic [FP_W-1:0]  req0_a_i;
   logic [FP_W-1:0]  req0_b_i;
   logic [1:0]       req0_op_i;
   logic [TAG_W-1:0] req0_tag_i;

   logic             req1_valid_i;
   logic             req1_ready_o;
   logic [FP_W-1:0]  req1_a_i;
   logic [FP_W-1:0]  req1_b_i;
   logic [1:0]       req1_op_i;
   logic [TAG_W-1:0] req1_tag_i;

   logic             rsp_valid_o;
   logic             rsp_ready_i;
   logic             rsp_src_o;
   logic [TAG_W-1:0] rsp_tag_o;
   logic [FP_W-1:0]  rsp_data_o;
   logic             rsp_err_o;

   modport master (
      output req0_valid_i, req0_a_i, req0_b_i, req0_op_i, req0_tag_i,
      output req1_valid_i, req1_a_i, req1_b_i, req1_op_i, req1_tag_i,
      output rsp_ready_i,
      input  req0_ready_o, req1_ready_o,
      input  rsp_valid_o, rsp_src_o, rsp_tag_o, rsp_data_o, rsp_err_o
   );

   modport slave (
      input  req0_valid_i, req0_a_i, req0_b_i, req0_op_i, req0_tag_i,
      input  req1_valid_i, req1_a_i, req1_b_i, req1_op_i, req1_tag_i,
      input  rsp_ready_i,
      output req0_ready_o, req1_ready_o,
      output rsp_valid_o, rsp_src_o, rsp_tag_o, rsp_data_o, rsp_err_o
   );
endinterface

// File: rtl/fp_alu_rr_arb.sv
// fp_alu_rr_arb
//   Two-way round-robin arbiter.
//   clk_i, rst_i : clock, async active-low reset
//   valid_i[1:0] : requester valids
//   en_i         : a grant this cycle is really taken (pipe not stalled)
//   grant_o[1:0] : one-hot grant (zero when nobody is valid)
//   last_grant resets to 1 so requester 0 wins the first tie.
module fp_alu_rr_arb (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] valid_i,
   input  logic       en_i,
   output logic [1:0] grant_o
);

   logic last_grant_q, last_grant_d;

   always_comb begin
      grant_o = 2'b00;
      case (valid_i)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         2'b11:   grant_o = last_grant_q ? 2'b01 : 2'b10;
         default: grant_o = 2'b00;
      endcase
      // Priority only rotates on a real accept; a stalled winner keeps its turn.
      last_grant_d = (en_i && (grant_o != 2'b00)) ? grant_o[1] : last_grant_q;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) last_grant_q <= 1'b1;
      else        last_grant_q <= last_grant_d;
   end

endmodule

// File: rtl/fp_alu_sched.sv
// fp_alu_sched
//   Shares one external combinational FP add/sub ALU between two requesters.
//   clk_i, rst_i       : clock, async active-low reset
//   bus (slave)        : req0/req1 valid/ready requests, rsp valid/ready response
//   alu_a_o/b_o/ctrl_o : operands and op driven from stage S0 (zero when empty)
//   alu_res_i          : ALU result, captured into R1
//   occ_o, busy_o      : ops in flight, occ_o != 0
//   Pipe: S0 -> R1 .. R_LAT; response = R_LAT. The whole pipe holds while the
//   response is valid and not taken; empty slots are not squeezed out.
module fp_alu_sched
   import fp_alu_pkg::*;
#(
   parameter int  FRAC_W = 52,
   parameter int  EXP_W  = 11,
   parameter int  LAT    = 2,
   parameter int  TAG_W  = 4,
   localparam int FP_W   = fp_width(FRAC_W, EXP_W),
   localparam int OCC_W  = $clog2(LAT + 2)
)(
   input  logic             clk_i,
   input  logic             rst_i,
   fp_alu_sched_if.slave    bus,
   output logic [FP_W-1:0]  alu_a_o,
   output logic [FP_W-1:0]  alu_b_o,
   output logic [OP_W-1:0]  alu_ctrl_o,
   input  logic [FP_W-1:0]  alu_res_i,
   output logic [OCC_W-1:0] occ_o,
   output logic             busy_o
);

   logic             s0_vld_q, s0_vld_d;
   logic [FP_W-1:0]  s0_a_q, s0_a_d, s0_b_q, s0_b_d;
   logic [OP_W-1:0]  s0_op_q, s0_op_d;
   logic [TAG_W-1:0] s0_tag_q, s0_tag_d;
   logic [SRC_W-1:0] s0_src_q, s0_src_d;

   logic             r_vld_q  [LAT], r_vld_d  [LAT];
   logic [FP_W-1:0]  r_data_q [LAT], r_data_d [LAT];
   logic             r_err_q  [LAT], r_err_d  [LAT];
   logic [TAG_W-1:0] r_tag_q  [LAT], r_tag_d  [LAT];
   logic [SRC_W-1:0] r_src_q  [LAT], r_src_d  [LAT];

   logic [OCC_W-1:0] occ_q, occ_d;

   logic       stall, acc, hs;
   logic [1:0] grant;

   assign stall = r_vld_q[LAT-1] & ~bus.rsp_ready_i;
   assign hs    = r_vld_q[LAT-1] &  bus.rsp_ready_i;
   assign acc   = (grant != 2'b00) & ~stall;

   fp_alu_rr_arb u_arb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .valid_i ({bus.req1_valid_i, bus.req0_valid_i}),
      .en_i    (~stall),
      .grant_o (grant)
   );

   assign bus.req0_ready_o = grant[0] & ~stall;
   assign bus.req1_ready_o = grant[1] & ~stall;

   always_comb begin
      s0_vld_d = s0_vld_q;
      s0_a_d   = s0_a_q;
      s0_b_d   = s0_b_q;
      s0_op_d  = s0_op_q;
      s0_tag_d = s0_tag_q;
      s0_src_d = s0_src_q;
      for (int i = 0; i < LAT; i++) begin
         r_vld_d[i]  = r_vld_q[i];
         r_data_d[i] = r_data_q[i];
         r_err_d[i]  = r_err_q[i];
         r_tag_d[i]  = r_tag_q[i];
         r_src_d[i]  = r_src_q[i];
      end
      occ_d = occ_q + OCC_W'(acc) - OCC_W'(hs);

      if (!stall) begin
         // S0: capture the granted request (or become empty)
         s0_vld_d = acc;
         if (acc) begin
            s0_src_d = grant[1];
            s0_a_d   = grant[1] ? bus.req1_a_i   : bus.req0_a_i;
            s0_b_d   = grant[1] ? bus.req1_b_i   : bus.req0_b_i;
            s0_op_d  = grant[1] ? bus.req1_op_i  : bus.req0_op_i;
            s0_tag_d = grant[1] ? bus.req1_tag_i : bus.req0_tag_i;
         end
         // R1: ALU result enters the pipe; illegal ops are zeroed and flagged here
         r_vld_d[0]  = s0_vld_q;
         r_err_d[0]  = s0_vld_q & op_illegal(s0_op_q);
         r_data_d[0] = (s0_vld_q && !op_illegal(s0_op_q)) ? alu_res_i : '0;
         r_tag_d[0]  = s0_tag_q;
         r_src_d[0]  = s0_src_q;
         // R2..R_LAT: plain shift
         for (int i = 1; i < LAT; i++) begin
            r_vld_d[i]  = r_vld_q[i-1];
            r_data_d[i] = r_data_q[i-1];
            r_err_d[i]  = r_err_q[i-1];
            r_tag_d[i]  = r_tag_q[i-1];
            r_src_d[i]  = r_src_q[i-1];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         s0_vld_q <= 1'b0;
         s0_a_q   <= '0;
         s0_b_q   <= '0;
         s0_op_q  <= '0;
         s0_tag_q <= '0;
         s0_src_q <= '0;
         for (int i = 0; i < LAT; i++) begin
            r_vld_q[i]  <= 1'b0;
            r_data_q[i] <= '0;
            r_err_q[i]  <= 1'b0;
            r_tag_q[i]  <= '0;
            r_src_q[i]  <= '0;
         end
         occ_q <= '0;
      end else begin
         s0_vld_q <= s0_vld_d;
         s0_a_q   <= s0_a_d;
         s0_b_q   <= s0_b_d;
         s0_op_q  <= s0_op_d;
         s0_tag_q <= s0_tag_d;
         s0_src_q <= s0_src_d;
         for (int i = 0; i < LAT; i++) begin
            r_vld_q[i]  <= r_vld_d[i];
            r_data_q[i] <= r_data_d[i];
            r_err_q[i]  <= r_err_d[i];
            r_tag_q[i]  <= r_tag_d[i];
            r_src_q[i]  <= r_src_d[i];
         end
         occ_q <= occ_d;
      end
   end

   assign alu_a_o    = s0_vld_q ? s0_a_q  : '0;
   assign alu_b_o    = s0_vld_q ? s0_b_q  : '0;
   assign alu_ctrl_o = s0_vld_q ? s0_op_q : '0;

   assign bus.rsp_valid_o = r_vld_q[LAT-1];
   assign bus.rsp_data_o  = r_data_q[LAT-1];
   assign bus.rsp_err_o   = r_err_q[LAT-1];
   assign bus.rsp_tag_o   = r_tag_q[LAT-1];
   assign bus.rsp_src_o   = r_src_q[LAT-1];

   assign occ_o  = occ_q;
   assign busy_o = (occ_q != '0);

endmodule

// File: tb/tb_fp_alu_sched.sv
// tb_fp_alu_sched
//   Bench for fp_alu_sched with an external real-arithmetic ALU. A transaction
//   level model (queue of accepted ops, round-robin priority bit, per-op count
//   of pipe advances still needed) predicts ready, response and occupancy.
module tb_fp_alu_sched;
   localparam int FRAC_W = 52;
   localparam int EXP_W  = 11;
   localparam int FP_W   = 64;
   localparam int LAT    = 2;
   localparam int TAG_W  = 4;
   localparam int OCC_W  = $clog2(LAT + 2);

   logic clk_i = 1'b0;
   logic rst_i;
   always #5 clk_i = ~clk_i;

   fp_alu_sched_if #(.FP_W(FP_W), .TAG_W(TAG_W)) bus ();

   logic [FP_W-1:0]  alu_a, alu_b, alu_res;
   logic [1:0]       alu_ctrl;
   logic [OCC_W-1:0] occ;
   logic             busy;

   fp_alu_sched #(.FRAC_W(FRAC_W), .EXP_W(EXP_W), .LAT(LAT), .TAG_W(TAG_W)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .bus        (bus),
      .alu_a_o    (alu_a),
      .alu_b_o    (alu_b),
      .alu_ctrl_o (alu_ctrl),
      .alu_res_i  (alu_res),
      .occ_o      (occ),
      .busy_o     (busy)
   );

   function automatic logic [63:0] fp_ref(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] op);
      case (op)
         2'b00:   return $realtobits($bitstoreal(a) + $bitstoreal(b));
         2'b01:   return $realtobits($bitstoreal(a) - $bitstoreal(b));
         default: return 64'h0;
      endcase
   endfunction

   // the shared ALU living outside the scheduler
   always_comb alu_res = fp_ref(alu_a, alu_b, alu_ctrl);

   typedef struct {
      logic [63:0] data;
      logic        err;
      logic        src;
      logic [3:0]  tag;
      int          rem;
   } exp_t;

   exp_t q[$];
   logic acc_src[$];
   logic last_g = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int n, input logic v, input logic [63:0] a, input logic [63:0] b,
                          input logic [1:0] op, input logic [3:0] tag);
      if (n == 0) begin
         bus.req0_valid_i = v; bus.req0_a_i = a; bus.req0_b_i = b;
         bus.req0_op_i = op; bus.req0_tag_i = tag;
      end else begin
         bus.req1_valid_i = v; bus.req1_a_i = a; bus.req1_b_i = b;
         bus.req1_op_i = op; bus.req1_tag_i = tag;
      end
   endtask

   // Called at a falling edge with inputs already applied; checks, advances
   // the model across the next rising edge, returns at the following falling edge.
   task automatic step();
      logic exp_rv, stall, g0, g1, r0, r1;
      exp_t e;
      #1;
      exp_rv = (q.size() > 0) && (q[0].rem == 0);
      stall  = exp_rv && !bus.rsp_ready_i;
      if (bus.req0_valid_i && bus.req1_valid_i) begin
         g0 = last_g; g1 = !last_g;
      end else begin
         g0 = bus.req0_valid_i; g1 = bus.req1_valid_i;
      end
      r0 = g0 && !stall;
      r1 = g1 && !stall;
      chk("rsp_valid", 64'(bus.rsp_valid_o), 64'(exp_rv));
      chk("occ", 64'(occ), 64'(q.size()));
      chk("busy", 64'(busy), 64'(q.size() != 0));
      chk("ready0", 64'(bus.req0_ready_o), 64'(r0));
      chk("ready1", 64'(bus.req1_ready_o), 64'(r1));
      if (exp_rv) begin
         chk("rsp_data", bus.rsp_data_o, q[0].data);
         chk("rsp_err", 64'(bus.rsp_err_o), 64'(q[0].err));
         chk("rsp_src", 64'(bus.rsp_src_o), 64'(q[0].src));
         chk("rsp_tag", 64'(bus.rsp_tag_o), 64'(q[0].tag));
      end
      if (!stall)
         for (int i = 0; i < q.size(); i++)
            if (q[i].rem > 0) q[i].rem--;
      if (exp_rv && bus.rsp_ready_i) void'(q.pop_front());
      if (r0) begin
         e.data = fp_ref(bus.req0_a_i, bus.req0_b_i, bus.req0_op_i);
         e.err = bus.req0_op_i[1]; e.src = 1'b0; e.tag = bus.req0_tag_i; e.rem = LAT;
         q.push_back(e); acc_src.push_back(1'b0); last_g = 1'b0;
      end
      if (r1) begin
         e.data = fp_ref(bus.req1_a_i, bus.req1_b_i, bus.req1_op_i);
         e.err = bus.req1_op_i[1]; e.src = 1'b1; e.tag = bus.req1_tag_i; e.rem = LAT;
         q.push_back(e); acc_src.push_back(1'b1); last_g = 1'b1;
      end
      @(negedge clk_i);
   endtask

   task automatic idle();
      set_req(0, 1'b0, '0, '0, 2'b00, '0);
      set_req(1, 1'b0, '0, '0, 2'b00, '0);
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   function automatic logic [1:0] rnd_op();
      int r;
      r = $urandom_range(0, 7);
      if (r < 3) return 2'b00;
      if (r < 6) return 2'b01;
      return (r == 6) ? 2'b10 : 2'b11;
   endfunction

   logic [63:0] held;

   initial begin
      rst_i = 1'b0;
      idle();
      bus.rsp_ready_i = 1'b1;
      #2;
      chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'h0);
      chk("rst_rsp_data", bus.rsp_data_o, 64'h0);
      chk("rst_rsp_tag", 64'(bus.rsp_tag_o), 64'h0);
      chk("rst_rsp_err", 64'(bus.rsp_err_o), 64'h0);
      chk("rst_occ", 64'(occ), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      @(negedge clk_i); @(negedge clk_i);
      rst_i = 1'b1;

      // 1: req0 1.0 + 2.0, tag 3
      set_req(0, 1'b1, 64'h3FF0000000000000, 64'h4000000000000000, 2'b00, 4'd3);
      step();
      idle();
      step(); step();
      chk("t1_valid", 64'(bus.rsp_valid_o), 64'h1);
      chk("t1_data", bus.rsp_data_o, 64'h4008000000000000);
      chk("t1_src", 64'(bus.rsp_src_o), 64'h0);
      chk("t1_tag", 64'(bus.rsp_tag_o), 64'h3);
      chk("t1_err", 64'(bus.rsp_err_o), 64'h0);
      step();

      // 2: req1 5.0 - 2.0
      set_req(1, 1'b1, 64'h4014000000000000, 64'h4000000000000000, 2'b01, 4'd9);
      step();
      idle();
      step(); step();
      chk("t2_data", bus.rsp_data_o, 64'h4008000000000000);
      chk("t2_src", 64'(bus.rsp_src_o), 64'h1);
      step();

      // 3: both valid for 4 cycles -> alternating grants
      acc_src.delete();
      for (int i = 0; i < 4; i++) begin
         set_req(0, 1'b1, rnd64(), rnd64(), 2'b00, 4'(i));
         set_req(1, 1'b1, rnd64(), rnd64(), 2'b01, 4'(8 + i));
         step();
      end
      idle();
      chk("t3_n_acc", 64'(acc_src.size()), 64'd4);
      for (int i = 0; i < 4 && i < acc_src.size(); i++)
         chk("t3_order", 64'(acc_src[i]), 64'(i % 2));
      for (int i = 0; i < 6; i++) step();

      // 4: fill the pipe with the consumer blocked
      bus.rsp_ready_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         set_req(0, 1'b1, rnd64(), rnd64(), 2'b00, 4'(i));
         set_req(1, 1'b1, rnd64(), rnd64(), 2'b01, 4'(i + 4));
         step();
      end
      chk("t4_occ_full", 64'(occ), 64'(LAT + 1));
      held = bus.rsp_data_o;
      for (int i = 0; i < 5; i++) step();
      chk("t4_hold_data", bus.rsp_data_o, held);
      idle();
      bus.rsp_ready_i = 1'b1;
      for (int i = 0; i < 6; i++) step();
      chk("t4_drained", 64'(occ), 64'h0);

      // 5: illegal op followed by a legal one
      set_req(0, 1'b1, 64'h3FF0000000000000, 64'h3FF0000000000000, 2'b10, 4'd5);
      step();
      set_req(0, 1'b1, 64'h3FF0000000000000, 64'h3FF0000000000000, 2'b00, 4'd6);
      step();
      idle();
      step();
      chk("t5_err", 64'(bus.rsp_err_o), 64'h1);
      chk("t5_data", bus.rsp_data_o, 64'h0);
      step();
      chk("t5_next_err", 64'(bus.rsp_err_o), 64'h0);
      chk("t5_next_data", bus.rsp_data_o, 64'h4000000000000000);
      step();

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         set_req(0, 1'($urandom_range(0, 1)), rnd64(), rnd64(), rnd_op(), 4'($urandom));
         set_req(1, 1'($urandom_range(0, 1)), rnd64(), rnd64(), rnd_op(), 4'($urandom));
         bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
         step();
      end
      idle();
      bus.rsp_ready_i = 1'b1;
      for (int i = 0; i < 2 * LAT + 4; i++) step();
      chk("rand_drained", 64'(occ), 64'h0);

      // 6: reset with two ops in flight
      set_req(0, 1'b1, 64'h3FF0000000000000, 64'h4000000000000000, 2'b00, 4'd1);
      step();
      idle();
      set_req(1, 1'b1, 64'h4014000000000000, 64'h4000000000000000, 2'b01, 4'd2);
      step();
      idle();
      chk("t6_inflight", 64'(occ), 64'd2);
      rst_i = 1'b0;
      #1;
      chk("t6_rsp_valid", 64'(bus.rsp_valid_o), 64'h0);
      chk("t6_occ", 64'(occ), 64'h0);
      chk("t6_busy", 64'(busy), 64'h0);
      q.delete();
      last_g = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b1;
      acc_src.delete();
      set_req(0, 1'b1, rnd64(), rnd64(), 2'b00, 4'd7);
      set_req(1, 1'b1, rnd64(), rnd64(), 2'b00, 4'd8);
      step();
      idle();
      chk("t6_first_tie", 64'(acc_src.size() > 0 ? acc_src[0] : 1'b1), 64'h0);
      for (int i = 0; i < 2 * LAT + 2; i++) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
